// File: rtl/a2d_pkg.sv
// Shared types, channel map and command-word helper for the A/D front end.
package a2d_pkg;

    localparam int SCLK_DIV_W = 5;

    localparam logic [2:0] CH_LFT   = 3'd0;
    localparam logic [2:0] CH_RGHT  = 3'd4;
    localparam logic [2:0] CH_STEER = 3'd5;
    localparam logic [2:0] CH_BATT  = 3'd6;

    // Divider preload leaves SCLK high for a front porch before the first fall.
    localparam logic [SCLK_DIV_W-1:0] DIV_PRELOAD = 5'b10111;
    localparam logic [SCLK_DIV_W-1:0] DIV_RISE    = 5'b01111;
    localparam logic [SCLK_DIV_W-1:0] DIV_FALL    = 5'b11111;

    typedef enum logic [1:0] {SLOT_LFT, SLOT_RGHT, SLOT_STEER, SLOT_BATT} slot_t;
    typedef enum logic [1:0] {IDLE, CNV, GAP, RD} state_t;
    typedef enum logic {SPI_IDLE, SPI_XFER} spi_state_t;

    function automatic logic [2:0] slot_ch(input slot_t slot);
        case (slot)
            SLOT_LFT:   slot_ch = CH_LFT;
            SLOT_RGHT:  slot_ch = CH_RGHT;
            SLOT_STEER: slot_ch = CH_STEER;
            default:    slot_ch = CH_BATT;
        endcase
    endfunction

    function automatic logic [15:0] cmd_word(input logic [2:0] ch);
        cmd_word = {2'b00, ch, 11'h000};
    endfunction

endpackage

// File: rtl/a2d_intf_if.sv
// Core-side results plus the SPI pins of the A/D front end.
interface a2d_intf_if;
    logic        nxt;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic [11:0] steer_pot;
    logic [11:0] batt;
    logic        vld;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;

    modport master (
        input  nxt, MISO,
        output lft_ld, rght_ld, steer_pot, batt, vld, SS_n, SCLK, MOSI
    );

    modport slave (
        output nxt, MISO,
        input  lft_ld, rght_ld, steer_pot, batt, vld, SS_n, SCLK, MOSI
    );
endinterface

// File: rtl/a2d_intf_spi_mnrch.sv
// 16-bit SPI master; one shift register serves both transmit and receive.
module spi_mnrch
    import a2d_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wrt,
    input  logic [15:0] wt_data,
    output logic        done,
    output logic [15:0] rd_data,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    spi_state_t            state;
    logic [SCLK_DIV_W-1:0] div_cnt;
    logic [15:0]           shft_reg;
    logic [4:0]            bit_cnt;
    logic                  miso_smpl;

    assign SCLK    = div_cnt[SCLK_DIV_W-1];
    assign MOSI    = shft_reg[15];
    assign rd_data = shft_reg;

    // MISO is captured just before each rise and shifted in on the following fall;
    // the fall after the 16th rise is suppressed so SCLK stays high as a back porch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SPI_IDLE;
            div_cnt   <= '1;
            shft_reg  <= '0;
            bit_cnt   <= '0;
            miso_smpl <= 1'b0;
            SS_n      <= 1'b1;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                SPI_IDLE: begin
                    if (wrt) begin
                        SS_n     <= 1'b0;
                        div_cnt  <= DIV_PRELOAD;
                        shft_reg <= wt_data;
                        bit_cnt  <= '0;
                        state    <= SPI_XFER;
                    end
                end
                SPI_XFER: begin
                    if (div_cnt == DIV_RISE) begin
                        miso_smpl <= MISO;
                        bit_cnt   <= bit_cnt + 5'd1;
                    end
                    if (div_cnt == DIV_FALL && bit_cnt == 5'd16) begin
                        shft_reg <= {shft_reg[14:0], miso_smpl};
                        SS_n     <= 1'b1;
                        done     <= 1'b1;
                        state    <= SPI_IDLE;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                        if (div_cnt == DIV_FALL && bit_cnt != 5'd0)
                            shft_reg <= {shft_reg[14:0], miso_smpl};
                    end
                end
                default: state <= SPI_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/a2d_intf.sv
// Round-robin A/D sequencer: convert, then read back, one channel per nxt strobe.
module a2d_intf
    import a2d_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    a2d_intf_if.master bus
);

    state_t      state;
    slot_t       slot;
    logic        wrt;
    logic        done;
    logic        vld;
    logic [15:0] rd_data;
    logic [15:0] cmd;
    logic [11:0] lft_ld, rght_ld, steer_pot, batt;
    logic        unused_rd_hi;

    assign cmd          = cmd_word(slot_ch(slot));
    assign unused_rd_hi = ^rd_data[15:12];

    assign bus.lft_ld    = lft_ld;
    assign bus.rght_ld   = rght_ld;
    assign bus.steer_pot = steer_pot;
    assign bus.batt      = batt;
    assign bus.vld       = vld;

    spi_mnrch u_spi (
        .clk     (clk),
        .rst     (rst),
        .wrt     (wrt),
        .wt_data (cmd),
        .done    (done),
        .rd_data (rd_data),
        .SS_n    (bus.SS_n),
        .SCLK    (bus.SCLK),
        .MOSI    (bus.MOSI),
        .MISO    (bus.MISO)
    );

    // wrt is registered, so raising it on the first done leaves SS_n high for one GAP clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            slot      <= SLOT_LFT;
            wrt       <= 1'b0;
            vld       <= 1'b0;
            lft_ld    <= '0;
            rght_ld   <= '0;
            steer_pot <= '0;
            batt      <= '0;
        end else begin
            wrt <= 1'b0;
            vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.nxt) begin
                        wrt   <= 1'b1;
                        state <= CNV;
                    end
                end
                CNV: begin
                    if (done) begin
                        wrt   <= 1'b1;
                        state <= GAP;
                    end
                end
                GAP: state <= RD;
                RD: begin
                    if (done) begin
                        case (slot)
                            SLOT_LFT:   lft_ld    <= rd_data[11:0];
                            SLOT_RGHT:  rght_ld   <= rd_data[11:0];
                            SLOT_STEER: steer_pot <= rd_data[11:0];
                            default:    batt      <= rd_data[11:0];
                        endcase
                        vld   <= 1'b1;
                        slot  <= slot_t'(slot + 2'd1);
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/a2d_intf.md
Name: a2d_intf

Overview:
- Round-robin front end between the Segway core and the off-chip 8-channel SPI A/D converter.
- Each `nxt` strobe runs one 2-transaction SPI conversion/readback on the current channel.
- The 12-bit result is latched into the register for that channel: left load cell, right load cell, steer pot or battery.
- Outputs feed rider-detect, steering and battery-low logic; the toplevel bench drives the analog side through the A/D model.

Parameters:
- SCLK_DIV_W, 5, width of the SCLK divider counter; SCLK period = 2^SCLK_DIV_W clk cycles (32).
- CH_LFT, 3'd0, A/D channel for the left load cell.
- CH_RGHT, 3'd4, A/D channel for the right load cell.
- CH_STEER, 3'd5, A/D channel for the steer pot.
- CH_BATT, 3'd6, A/D channel for the battery.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  asynchronous, active-high reset.
- nxt  in  1  one-clk strobe: start a conversion on the current round-robin slot.
- lft_ld  out  12  last left load-cell reading.
- rght_ld  out  12  last right load-cell reading.
- steer_pot  out  12  last steer-pot reading.
- batt  out  12  last battery reading.
- vld  out  1  one-clk pulse when a result register updates.
- SS_n  out  1  A/D slave select, active low.
- SCLK  out  1  SPI clock.
- MOSI  out  1  SPI data to A/D.
- MISO  in  1  SPI data from A/D.

Behaviour:
- Reset (asynchronous) state:
  - all four result registers = 0; vld = 0.
  - SS_n = 1, SCLK = 1, MOSI = 0.
  - round-robin slot = 0 (left); FSM in IDLE.
- Round-robin order: LFT -> RGHT -> STEER -> BATT -> LFT. A 2-bit slot counter selects the channel. The slot advances only when a result is written.
- FSM states and transitions:
  - IDLE: on nxt, issue SPI write of {2'b00, ch[2:0], 11'h000}; go to CNV.
  - CNV: wait spi_done; go to GAP.
  - GAP: exactly one clk idle with SS_n high; then issue a second SPI write of the same command word; go to RD.
  - RD: on spi_done, write rd_data[11:0] into the slot's register, pulse vld the same cycle, advance slot; go to IDLE.
- nxt while not in IDLE is ignored; no queueing.
- nxt on the same cycle as a RD completion is also ignored, because the FSM is not yet in IDLE.
- rd_data[15:12] is discarded.
- Latency from nxt to vld: 2 x (SPI transaction time) + 1 GAP cycle + 2 FSM cycles; fixed, 1 of 2 bench-checkable values ±1.
- SPI master (mode 0 as seen by the A/D):
  - SCLK idles high and equals div_cnt[4].
  - On wrt: SS_n falls next clk; div_cnt preloads 5'b10111, giving a front porch before the first SCLK fall.
  - MOSI shifts MSB first on each SCLK fall.
  - MISO is sampled on each SCLK rise; a 16-bit shift register serves both tx and rx.
  - After the 16th rise: a back porch holds SCLK high, then SS_n rises and done pulses for one clk with rd_data valid.
  - Exactly 16 SCLK rising edges per transaction.
- Result registers hold their value between updates; there is no wrap or saturation since data is unsigned 12-bit.
- rst mid-transaction: SS_n and SCLK return high immediately, the partial result is discarded, and the slot returns to 0.

Decomposition:
- Shared package a2d_pkg holds:
  - channel constants;
  - slot typedef enum {SLOT_LFT, SLOT_RGHT, SLOT_STEER, SLOT_BATT};
  - FSM state typedef enum {IDLE, CNV, GAP, RD};
  - the command-word construction function.
- One sub-module, spi_mnrch: 16-bit SPI master with wrt, wt_data[15:0], done, rd_data[15:0], SS_n, SCLK, MOSI, MISO; same clk and rst.
- a2d_intf contains the FSM, the slot counter and the result registers.

Test Plan:
- Reset with rst=1 for 10 clks, then release -> all four outputs = 0, SS_n = 1, SCLK = 1, vld = 0, no SCLK toggling with nxt = 0 for 1000 clks.
- A/D model ch0=0x350, ch4=0x000, ch5=0x800, ch6=0xA98; four nxt pulses, each after vld -> lft_ld = 0x350, rght_ld = 0x000, steer_pot = 0x800, batt = 0xA98, in that update order.
- Single nxt -> SS_n low exactly twice; 16 SCLK rises each; first MOSI word = 0x0000; slot 2 next command = 0x2800 (ch5); exactly one vld pulse.
- nxt pulsed every 10 clks during a conversion -> only one result written; slot advances by exactly 1.
- Assert rst during the 8th SCLK of the readback for steer slot -> SS_n = 1 within 1 clk; steer_pot stays 0; next nxt targets ch0.
- Change model ch0 from 0x350 to 0x000 between rounds -> lft_ld updates on the 5th vld; other registers unchanged.
